// File: rtl/pc_unit_if.sv
// Fetch-stage request/response bundle for pc_unit: redirect requests in,
// current fetch PC, status flags and RAS occupancy out.
interface pc_unit_if #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic            i_stall;
  logic            i_exc_valid;
  logic [PC_W-1:0] i_exc_vector;
  logic            i_br_taken;
  logic [PC_W-1:0] i_br_target;
  logic            i_jmp_valid;
  logic [PC_W-1:0] i_jmp_target;
  logic            i_call;
  logic            i_ret;

  logic [PC_W-1:0]  o_pc;
  logic [PC_W-1:0]  o_pc_plus;
  logic             o_redirect;
  logic             o_misalign;
  logic [CNT_W-1:0] o_ras_cnt;

  modport master (
    output i_stall, i_exc_valid, i_exc_vector, i_br_taken, i_br_target,
           i_jmp_valid, i_jmp_target, i_call, i_ret,
    input  o_pc, o_pc_plus, o_redirect, o_misalign, o_ras_cnt
  );

  modport slave (
    input  i_stall, i_exc_valid, i_exc_vector, i_br_taken, i_br_target,
           i_jmp_valid, i_jmp_target, i_call, i_ret,
    output o_pc, o_pc_plus, o_redirect, o_misalign, o_ras_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised redirect selection, stall hold,
// forced target alignment and a circular return-address stack.
module pc_unit #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  pc_unit_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]  KEEP_MASK = {PC_W{1'b1}} << ALIGN_BITS;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_EXC,
    SEL_BR,
    SEL_RET,
    SEL_JMP
  } sel_e;

  sel_e             sel;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_plus;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  src;
  logic             load;
  logic             push;

  assign pc_plus = pc_q + PC_W'(INC);

  always_comb begin
    sel = SEL_SEQ;
    if (bus.i_exc_valid)                                  sel = SEL_EXC;
    else if (bus.i_br_taken)                              sel = SEL_BR;
    else if (bus.i_stall)                                 sel = SEL_HOLD;
    else if (bus.i_jmp_valid && bus.i_ret && cnt_q != '0) sel = SEL_RET;
    else if (bus.i_jmp_valid)                             sel = SEL_JMP;
  end

  always_comb begin
    src        = '0;
    load       = 1'b0;
    push       = 1'b0;
    pc_d       = pc_plus;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;

    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_EXC: begin
        src  = bus.i_exc_vector;
        load = 1'b1;
      end
      SEL_BR: begin
        src  = bus.i_br_target;
        load = 1'b1;
      end
      SEL_RET: begin
        src   = ras_q[ptr_q - PTR_W'(1)];
        load  = 1'b1;
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
      SEL_JMP: begin
        src  = bus.i_jmp_target;
        load = 1'b1;
        // A return that found the stack empty still must not push.
        if (bus.i_call && !bus.i_ret) begin
          push  = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: pc_d = pc_plus;
    endcase

    if (load) begin
      pc_d       = src & KEEP_MASK;
      redirect_d = 1'b1;
      misalign_d = |(src & ~KEEP_MASK);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stack storage needs no reset: entries are only read when cnt_q says valid.
  always_ff @(posedge i_clk) begin
    if (push) ras_q[ptr_q] <= pc_plus;
  end

  assign bus.o_pc      = pc_q;
  assign bus.o_pc_plus = pc_plus;
  assign bus.o_redirect = redirect_q;
  assign bus.o_misalign = misalign_q;
  assign bus.o_ras_cnt  = cnt_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined CPU fetch stage. It replaces the plain PC register and adds:
- stall hold
- prioritised redirect selection (exception, branch, jump, return)
- a configurable reset vector
- a circular return-address stack (RAS) for call/return prediction
- a registered misalignment flag

It outputs the current fetch address to instruction memory and the IF/ID pipeline register.

Parameters:
- PC_W, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, value loaded into o_pc while reset is asserted.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of PC LSBs that must be zero.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_stall, in, 1, hold PC (pipeline hazard).
- i_exc_valid, in, 1, exception redirect request.
- i_exc_vector, in, PC_W, exception handler address.
- i_br_taken, in, 1, resolved branch taken / mispredict redirect.
- i_br_target, in, PC_W, branch target.
- i_jmp_valid, in, 1, unconditional jump request.
- i_jmp_target, in, PC_W, jump target.
- i_call, in, 1, qualifies i_jmp_valid as a call (push the return address).
- i_ret, in, 1, qualifies i_jmp_valid as a return (pop the RAS).
- o_pc, out, PC_W, current fetch PC.
- o_pc_plus, out, PC_W, o_pc + INC; combinational from o_pc.
- o_redirect, out, 1, registered pulse: PC was loaded from a non-sequential source.
- o_misalign, out, 1, registered: the last loaded target had nonzero low ALIGN_BITS.
- o_ras_cnt, out, $clog2(RAS_DEPTH)+1, number of valid RAS entries.

Behaviour:
- Reset: asynchronous and active-low, clocked by i_clk. While asserted:
  - o_pc = RESET_VEC
  - o_redirect = 0, o_misalign = 0
  - o_ras_cnt = 0, RAS pointer = 0
  - RAS contents are don't-care.
  - Reset mid-operation discards all pending state immediately.
- Next-PC selection, evaluated every edge in strict priority order:
  1. i_exc_valid: next = i_exc_vector. Overrides stall.
  2. i_br_taken: next = i_br_target. Overrides stall.
  3. i_stall: next = o_pc. Jump, call and return are ignored; no RAS change.
  4. i_jmp_valid & i_ret & o_ras_cnt != 0: next = RAS top; pop.
  5. i_jmp_valid (includes a return with an empty RAS): next = i_jmp_target. If i_call is set, push o_pc_plus.
  6. Otherwise: next = o_pc + INC, wrapping modulo 2^PC_W.
- Latency:
  - A redirect presented in cycle N appears on o_pc after edge N+1 (one cycle).
  - o_redirect is 1 for exactly the cycle following a load from case 1, 2, 4 or 5; otherwise 0.
- Alignment:
  - On every load, the low ALIGN_BITS of the next PC are forced to 0.
  - o_misalign is registered to 1 if those bits of the selected source were nonzero, else 0.
  - Sequential increments never set o_misalign.
- RAS behaviour:
  - It is a circular stack.
  - Push writes at ptr, then ptr+1. Pop reads ptr-1, then ptr-1.
  - Push when full (cnt == RAS_DEPTH) overwrites the oldest entry; cnt saturates at RAS_DEPTH.
  - Pop when empty never occurs: it falls back to case 5 without a pop.
  - i_call and i_ret both set with i_jmp_valid: the return wins, pop only, no push.
  - i_call or i_ret without i_jmp_valid: ignored.
  - Any exception or branch redirect in the same cycle suppresses the RAS operation.
  - RAS state is not flushed by exceptions or branches.
- Arithmetic is unsigned modulo 2^PC_W. Carry-out is discarded.

Test Plan:
- Reset and sequential fetch: assert i_rst_n=0 mid-run, then release; no requests for 4 edges → o_pc = 0, 4, 8, 12, 16; o_redirect stays 0.
- Stall versus redirect: with o_pc=0x20, assert i_stall with i_jmp_valid, target 0x100 → o_pc holds 0x20 and o_ras_cnt is unchanged. Then assert i_stall with i_br_taken, target 0x80 → o_pc=0x80 and o_redirect=1 for one cycle.
- Priority: in the same cycle assert i_exc_valid (0x1000), i_br_taken (0x200) and i_jmp_valid (0x300) → o_pc=0x1000. Next cycle assert i_br_taken plus i_jmp_valid → o_pc=0x200.
- Call/return pair: call from 0x40 to 0x400 → o_ras_cnt=1. Return with i_jmp_target=0xDEAD0 → o_pc=0x44, o_ras_cnt=0. Return again while empty → o_pc=0xDEAD0.
- RAS overflow: with RAS_DEPTH=4, do 5 nested calls from PCs A..E, then 5 returns → the first 4 returns yield E+4, D+4, C+4, B+4; the 5th uses i_jmp_target; o_ras_cnt peaks at 4.
- Misalignment and wrap: jump to 0x103 → o_pc=0x100, o_misalign=1. Next sequential cycle → o_misalign=0. Start from o_pc=0xFFFF_FFFC sequential → o_pc=0x0000_0000.
